mem_port_arbiter: RTL

//  Shares one single-port synchronous memory between instruction fetch and data

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data requester handshakes and the memory-macro port shared by the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8
) ();
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              busy;

    // arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // core/memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch
// and data load/store. Data wins over fetch unless fetch has been passed over
// STARVE_MAX times in a row.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | no transaction; arbitrate pending requests, capture winner
//  S_ISSUE | mem_en strobe for one cycle (mem_we for stores)
//  S_WAIT  | loads only: RD_LAT cycles, capture mem_rdata on the last one
//  S_ACK   | one-cycle ack pulse to the winning requester
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int LAT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              win_fetch;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              any_req;
    logic              pick_data;
    logic              lat_done;
    logic              unused_addr_bits;

    assign any_req   = bus.if_req | bus.d_req;
    assign pick_data = bus.d_req & ~(bus.if_req & (starve_cnt == CNT_MAX));
    assign lat_done  = (lat_cnt == '0);

    // byte-lane and above-range address bits are don't-care
    assign unused_addr_bits = ^{bus.if_addr, bus.d_addr};

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = we_q ? S_ACK : S_WAIT;
            S_WAIT:  if (lat_done) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // capture the winning request and update fetch-starvation history at grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_fetch  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= '0;
        end else if (state == S_IDLE && any_req) begin
            win_fetch <= ~pick_data;
            if (pick_data) begin
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr[ADDR_W+1:2];
                wdata_q <= bus.d_wdata;
                // a data grant over a pending fetch implies starve_cnt < CNT_MAX,
                // so the increment saturates by construction
                starve_cnt <= bus.if_req ? starve_cnt + CNT_W'(1) : '0;
            end else begin
                we_q       <= 1'b0;
                addr_q     <= bus.if_addr[ADDR_W+1:2];
                starve_cnt <= '0;
            end
        end
    end

    // read-latency down-counter: loaded on issue, terminal count at zero
    always_ff @(posedge clk) begin
        if (!rst)                            lat_cnt <= '0;
        else if (state == S_ISSUE)           lat_cnt <= LAT_LAST;
        else if (state == S_WAIT && !lat_done) lat_cnt <= lat_cnt - LAT_W'(1);
    end

    // load data lands in the winner's rdata register on the last wait cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (state == S_WAIT && lat_done) begin
            if (win_fetch) if_rdata_q <= bus.mem_rdata;
            else           d_rdata_q  <= bus.mem_rdata;
        end
    end

    // state-decoded strobes
    always_comb begin
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        bus.if_ack = 1'b0;
        bus.d_ack  = 1'b0;
        bus.busy   = (state != S_IDLE);
        case (state)
            S_ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q;
            end
            S_ACK: begin
                bus.if_ack = win_fetch;
                bus.d_ack  = ~win_fetch;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule
